// File: rtl/pu_sequencer.sv
// Batch sequencer for the four-operand PU: issues one operand set per cycle and aligns results via a valid-token line.
// Define PU_SEQ_ACC_EN to enable the running result accumulator on acc.
module pu_sequencer #(
  parameter int XLEN     = 5,
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      count,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_num1,
  input  logic [XLEN-1:0]       in_num2,
  input  logic [XLEN-1:0]       in_num3,
  input  logic [XLEN-1:0]       in_num4,
  output logic [XLEN-1:0]       pu_num1,
  output logic [XLEN-1:0]       pu_num2,
  output logic [XLEN-1:0]       pu_num3,
  output logic [XLEN-1:0]       pu_num4,
  input  logic [XLEN-1:0]       pu_result,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_result,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN+CNT_W-1:0] acc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PIPE_LAT-1:0] LINE_EMPTY = {PIPE_LAT{1'b0}};
  localparam logic [XLEN-1:0]     X_ZERO     = {XLEN{1'b0}};

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    remaining_r, count_r, retired_r;
  logic [PIPE_LAT-1:0] vline_r, vline_s;
  logic                accept_s, tail_s, launch_s;
  logic                in_ready_r, busy_r, done_r, out_valid_r;
  logic [XLEN-1:0]     pu_num1_r, pu_num2_r, pu_num3_r, pu_num4_r, out_result_r;

  // in_ready_r mirrors state RUN exactly, so it doubles as the accept qualifier.
  assign accept_s = in_valid & in_ready_r;
  assign tail_s   = vline_r[PIPE_LAT-1];
  assign launch_s = (state_r == IDLE) & start;

  // Valid-token line: a 1 enters on accept, a 0 (bubble) otherwise.
  always_comb begin
    vline_s    = vline_r << 1'b1;
    vline_s[0] = accept_s;
  end

  // Next-state decode for the batch FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (count != CNT_ZERO) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && (remaining_r == CNT_ONE)) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if ((retired_r == count_r) && (vline_r == LINE_EMPTY)) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, flag outputs and token line; flags derive from the next state so they are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      vline_r     <= LINE_EMPTY;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == RUN);
      busy_r      <= (state_s != IDLE);
      done_r      <= (state_s == DONE);
      out_valid_r <= tail_s;
      vline_r     <= vline_s;
    end
  end

  // Batch bookkeeping: remaining sets to accept and results retired so far.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining_r <= CNT_ZERO;
      count_r     <= CNT_ZERO;
      retired_r   <= CNT_ZERO;
    end else begin
      if (launch_s) begin
        remaining_r <= count;
        count_r     <= count;
      end else if (accept_s) begin
        remaining_r <= remaining_r - CNT_ONE;
      end
      if (launch_s) begin
        retired_r <= CNT_ZERO;
      end else if (tail_s) begin
        retired_r <= retired_r + CNT_ONE;
      end
    end
  end

  // Operand drive registers hold across bubbles; result is captured with its token.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pu_num1_r    <= X_ZERO;
      pu_num2_r    <= X_ZERO;
      pu_num3_r    <= X_ZERO;
      pu_num4_r    <= X_ZERO;
      out_result_r <= X_ZERO;
    end else begin
      if (accept_s) begin
        pu_num1_r <= in_num1;
        pu_num2_r <= in_num2;
        pu_num3_r <= in_num3;
        pu_num4_r <= in_num4;
      end
      if (tail_s) begin
        out_result_r <= pu_result;
      end
    end
  end

`ifdef PU_SEQ_ACC_EN
  logic [XLEN+CNT_W-1:0] acc_r;

  // Running sum of this batch's results, held after done until the next launch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= {(XLEN+CNT_W){1'b0}};
    end else if (launch_s) begin
      acc_r <= {(XLEN+CNT_W){1'b0}};
    end else if (tail_s) begin
      acc_r <= acc_r + {{CNT_W{1'b0}}, pu_result};
    end
  end

  assign acc = acc_r;
`else
  assign acc = {(XLEN+CNT_W){1'b0}};
`endif

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign pu_num1    = pu_num1_r;
  assign pu_num2    = pu_num2_r;
  assign pu_num3    = pu_num3_r;
  assign pu_num4    = pu_num4_r;

endmodule

// File: tb/tb_pu_sequencer.sv
// Self-checking bench for pu_sequencer: randomized batches against a cycle-timestamp reference model.
// Honours PU_SEQ_ACC_EN for the expected acc value.
module tb_pu_sequencer;
  localparam int XLEN = 5, PIPE_LAT = 3, CNT_W = 4, AW = XLEN + CNT_W;
  localparam int BIG = 1 << 30;

  logic            clk = 1'b0;
  logic            rst, start, in_valid, in_ready, out_valid, busy, done;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0] in_num1, in_num2, in_num3, in_num4;
  logic [XLEN-1:0] pu_num1, pu_num2, pu_num3, pu_num4, pu_result, out_result;
  logic [XLEN-1:0] pu_d1 = '0, pu_d2 = '0;
  logic [AW-1:0]   acc;

  int vectors = 0, miscompares = 0;
  // Reference model: each expected result is stamped with the cycle it must appear in.
  int cyc = 0, busy_from = 0, done_cyc = -1, rem = 0, acc_exp = 0;
  int              q_cyc[$];
  logic [XLEN-1:0] q_val[$];
  logic [XLEN-1:0] tab[$];
  bit              pat[$];
  logic [XLEN-1:0] last_n[4];

  pu_sequencer #(.XLEN(XLEN), .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num1(in_num1), .in_num2(in_num2), .in_num3(in_num3), .in_num4(in_num4),
    .pu_num1(pu_num1), .pu_num2(pu_num2), .pu_num3(pu_num3), .pu_num4(pu_num4),
    .pu_result(pu_result), .out_valid(out_valid), .out_result(out_result),
    .busy(busy), .done(done), .acc(acc)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] pu_f(input logic [XLEN-1:0] a, b, c, d);
    return a + b + c + d;
  endfunction

  // PU stand-in: result stable PIPE_LAT edges after its operands were driven.
  always @(posedge clk) begin
    pu_d1 <= pu_f(pu_num1, pu_num2, pu_num3, pu_num4);
    pu_d2 <= pu_d1;
  end
  assign pu_result = pu_d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit model_busy();
    return (cyc >= busy_from) && (cyc <= done_cyc);
  endfunction

  task automatic check_outputs();
    bit ov;
    ov = (q_cyc.size() != 0) && (q_cyc[0] == cyc);
    chk("in_ready", in_ready, rem > 0);
    chk("busy", busy, model_busy());
    chk("done", done, cyc == done_cyc);
    chk("out_valid", out_valid, ov);
    if (ov) begin
      acc_exp += q_val[0];
      chk("out_result", out_result, q_val[0]);
      void'(q_cyc.pop_front());
      void'(q_val.pop_front());
    end
    chk("pu_num1", pu_num1, last_n[0]);
    chk("pu_num2", pu_num2, last_n[1]);
    chk("pu_num3", pu_num3, last_n[2]);
    chk("pu_num4", pu_num4, last_n[3]);
`ifdef PU_SEQ_ACC_EN
    chk("acc", acc, acc_exp);
`else
    chk("acc", acc, 0);
`endif
  endtask

  task automatic model_edge();
    if (!model_busy() && start) begin
      busy_from = cyc + 1;
      acc_exp   = 0;
      if (count == 0) done_cyc = cyc + 1;
      else begin
        rem      = count;
        done_cyc = BIG;
      end
    end else if (rem > 0) begin
      if (pat.size() != 0) void'(pat.pop_front());
      if (in_valid) begin
        q_cyc.push_back(cyc + 1 + PIPE_LAT);
        q_val.push_back(pu_f(in_num1, in_num2, in_num3, in_num4));
        last_n = '{in_num1, in_num2, in_num3, in_num4};
        if (tab.size() != 0) void'(tab.pop_front());
        rem--;
        if (rem == 0) done_cyc = cyc + 2 + PIPE_LAT;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    if (rem > 0) begin
      if (pat.size() != 0) in_valid = pat[0];
      else if (tab.size() != 0) in_valid = 1'b1;
      else in_valid = ($urandom_range(0, 3) != 0);
    end else begin
      in_valid = 1'($urandom_range(0, 1));
    end
    if (tab.size() != 0) begin
      in_num1 = '0; in_num2 = '0; in_num3 = tab[0]; in_num4 = '0;
    end else begin
      in_num1 = XLEN'($urandom); in_num2 = XLEN'($urandom);
      in_num3 = XLEN'($urandom); in_num4 = XLEN'($urandom);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pu_num1"}, pu_num1, 0);
    chk({tag, "_pu_num2"}, pu_num2, 0);
    chk({tag, "_pu_num3"}, pu_num3, 0);
    chk({tag, "_pu_num4"}, pu_num4, 0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_acc"}, acc, 0);
  endtask

  task automatic model_reset();
    q_cyc.delete(); q_val.delete(); tab.delete(); pat.delete();
    rem = 0; done_cyc = -1; busy_from = 0; acc_exp = 0;
    last_n = '{default: '0};
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
  endtask

  task automatic batch(input int c, input int extra_start);
    int i;
    start = 1'b1;
    count = c[CNT_W-1:0];
    drive_ops();
    step();
    start = 1'b0;
    for (i = 0; i < 200 && (model_busy() || rem > 0 || q_cyc.size() != 0); i++) begin
      if (i == extra_start) begin
        start = 1'b1;
        count = 4'd7;
      end else begin
        start = 1'b0;
      end
      drive_ops();
      step();
    end
    start = 1'b0;
    assert (i < 200) else begin
      miscompares++;
      $error("FAIL batch_timeout: observed %0d cycles expected fewer than 200", i);
    end
    chk("batch_end_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; count = '0; in_valid = 1'b0;
    in_num1 = '0; in_num2 = '0; in_num3 = '0; in_num4 = '0;
    last_n = '{default: '0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("rst_state");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Abort a count=5 batch after two accepts, then run a count=1 batch.
    repeat (2) tab.push_back(XLEN'($urandom));
    start = 1'b1;
    count = 4'd5;
    drive_ops();
    step();
    start = 1'b0;
    repeat (2) begin
      drive_ops();
      step();
    end
    do_reset();
    batch(1, -1);

    // count=3 with PU result 4, 7, 9 back to back.
    tab = '{5'd4, 5'd7, 5'd9};
    batch(3, -1);
`ifdef PU_SEQ_ACC_EN
    chk("acc_sum_3", acc, 20);
`else
    chk("acc_sum_3", acc, 0);
`endif

    // in_valid pattern with bubbles.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    batch(4, -1);

    // Empty batch.
    batch(0, -1);

    // Second start during RUN must be ignored.
    batch(2, 1);

    // Maximum batch of results equal to 31.
    repeat (15) tab.push_back(5'd31);
    batch(15, -1);
`ifdef PU_SEQ_ACC_EN
    chk("acc_sum_15", acc, 465);
`else
    chk("acc_sum_15", acc, 0);
`endif

    // Randomized batches with idle gaps and stray start pulses.
    repeat (25) begin
      repeat ($urandom_range(0, 3)) begin
        start = 1'b0;
        drive_ops();
        step();
      end
      batch(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)));
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pu_sequencer.md
# pu_sequencer

Batch controller for the XLEN-bit four-operand processing unit. It accepts operand sets through a valid/ready handshake and drives them onto the PU inputs one set per cycle. A valid token travels alongside each set through a delay line matched to the PU pipeline depth, which aligns every PU result with its issue. The block reports busy/done around a programmed batch and sits between the operand source and the PU instance.

## Interface
- XLEN, 5, operand/result width (matches PU)
- PIPE_LAT, 3, PU latency in clock edges from a pu_num* update to the matching pu_result being stable (≥1)
- CNT_W, 4, width of the batch-count field
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- start  in  1  batch start request, sampled only in IDLE
- count  in  CNT_W  number of operand sets in the batch, latched on start
- in_valid  in  1  operand set present
- in_ready  out  1  sequencer accepts a set this cycle
- in_num1..in_num4  in  XLEN each  operand set
- pu_num1..pu_num4  out  XLEN each  registered PU operand drives
- pu_result  in  XLEN  PU output
- out_valid  out  1  out_result holds a batch result (1-cycle pulse per result)
- out_result  out  XLEN  registered copy of pu_result
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle batch-complete pulse
- acc  out  XLEN+CNT_W  running sum of batch results (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1, count≠0 → RUN; latch remaining=count; clear retired counter and acc.
  - start=1, count=0 → DONE.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready=1.
  - Accept (in_valid && in_ready): pu_num1..4 ← in_num1..4; shift a 1 into the valid line; remaining−1.
  - No accept: pu_num* hold their values; shift a 0 in (bubble).
  - Accepting the last set (remaining==1) → DRAIN.
- DRAIN:
  - in_ready=0; the valid line keeps shifting 0s.
  - → DONE on the edge where retired reaches the latched count and the line is empty.
- DONE: done=1 for exactly one cycle → IDLE.
- Valid line: PIPE_LAT bits.
  - Its tail bit registers out_valid and, in the same edge, out_result ← pu_result.
  - Each retirement increments retired.
- start outside IDLE is ignored. The PU has no stall, so there is no output back-pressure.
- Counters are CNT_W bits. count=2^CNT_W−1 is the maximum batch; no wrap occurs within a batch.

## Timing
- Reset (rst low, asynchronous): state=IDLE; in_ready, out_valid, busy, done = 0; pu_num1..4, out_result, acc, counters and the valid line all 0.
- start sampled at edge e → busy=1 from e; in_ready=1 from e (RUN).
- Set accepted at edge k → pu_num* updated at k → out_valid=1 and out_result valid in the cycle after edge k+PIPE_LAT.
- Sustained throughput: 1 set/cycle. Bubbles in in_valid appear as identical gaps in out_valid.
- Last accept at edge k → done=1 in the cycle after edge k+PIPE_LAT+1 → busy=0 one cycle later.
- count=0: done one cycle after the start edge, with no in_ready or out_valid.
- Reset mid-batch aborts at once: no done pulse, and in-flight results are dropped.

## Configuration
- PU_SEQ_ACC_EN defined:
  - On each out_valid edge, acc ← acc + zero-extended pu_result.
  - acc is cleared on batch start and held after done until the next start.
- Not defined: acc is tied to 0 and no adder is synthesised.

## Test plan
- Reset mid-RUN (count=5, 2 sets accepted, rst low one cycle) → all outputs 0, state IDLE, no done; a following start with count=1 completes normally.
- count=3, in_valid held 1, PIPE_LAT=3; PU model with result=num3 and num3 = 4, 7, 9 → out_valid over 3 consecutive cycles, out_result 4, 7, 9; done one cycle after the last out_valid; acc=20 with PU_SEQ_ACC_EN.
- count=4 with in_valid pattern 1,0,0,1,1,0,1 → out_valid shows the same pattern delayed by PIPE_LAT+1; done after the 4th result; in_ready=0 from the 4th accept onward.
- start=1 with count=0 → done pulse one cycle after the start edge; in_ready and out_valid never 1; busy high for exactly that one cycle.
- start pulsed during RUN with count=2 in flight → batch still finishes after 2 results; the second start has no effect.
- count=15, back-to-back input, PU result=31 each → 15 out_valid pulses; acc=465 (fits in XLEN+CNT_W=9 bits) with the macro, acc=0 without it.
